// File: rtl/line_memory_pkg.sv
// Shared types and helpers for the line-granular main-memory model.
package line_memory_pkg;

    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Line number of a byte address; callers truncate to their index width,
    // so upper address bits alias onto the same lines.
    function automatic logic [63:0] idx_of(input logic [63:0] addr);
        return addr >> LINE_OFFSET_W;
    endfunction

endpackage

// File: rtl/line_memory_if.sv
// Request/response bundle between the cache memory port and the line memory.
interface line_memory_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic [LINE_W-1:0] data_o;
    logic              ack_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  data_o, ack_o
    );

    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/line_mem_array.sv
// DEPTH x LINE_W storage with a synchronous write port and a registered read port.
module line_mem_array #(
    parameter int DEPTH  = 512,
    parameter int LINE_W = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Storage is deliberately unreset so contents survive a controller reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[ridx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency whole-line memory: one request at a time, one-cycle ack pulse.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    line_memory_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              rd_valid_q, rd_valid_d;

    logic              mem_we_s;
    logic              mem_re_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [LINE_W-1:0] mem_rdata_s;

    assign req_idx_s = IDX_W'(idx_of(64'(bus.addr_i)));

    // Next-state, request latching and array strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        mem_we_s   = 1'b0;
        mem_re_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 2);
                    idx_d   = req_idx_s;
                    write_d = bus.write_i;
                    wdata_d = bus.data_i;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // A dropped enable wins even on the completing edge.
                if (!bus.enable_i) begin
                    state_d = IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (write_q) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_re_s   = 1'b1;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state; the line array itself is never reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            write_q    <= 1'b0;
            wdata_q    <= {LINE_W{1'b0}};
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    line_mem_array #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we_s),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .re_i    (mem_re_s),
        .ridx_i  (idx_q),
        .rdata_o (mem_rdata_s)
    );

    // The read register has no reset, so data_o reads zero until the first read lands.
    assign bus.data_o = rd_valid_q ? mem_rdata_s : {LINE_W{1'b0}};
    assign bus.ack_o  = ack_q;

endmodule
